// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target block.
package i2c_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StAddr,
      StAddrAck,
      StPtr,
      StPtrAck,
      StWdata,
      StWdataAck,
      StRdata,
      StRdataAck,
      StIgnore
   } i2c_tgt_state_t;

   localparam logic        I2C_ACK       = 1'b0;
   localparam logic        I2C_NACK      = 1'b1;
   localparam int unsigned I2C_BYTE_BITS = 8;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers plus edge and START/STOP detection.
// Define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample majority-free glitch filter.
module i2c_bus_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);

   logic [1:0] scl_sync_q, sda_sync_q;
   logic       scl_s;
   logic       scl_prev_q, sda_prev_q;

   // Idle bus is high, so reset every stage to 1 to avoid a false edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
      end else begin
         scl_sync_q <= {scl_sync_q[0], scl_i};
         sda_sync_q <= {sda_sync_q[0], sda_i};
      end
   end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
   logic scl_hist_q, sda_hist_q, scl_filt_q, sda_filt_q;

   // Accept a new level only once three successive samples agree.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scl_hist_q <= 1'b1;
         sda_hist_q <= 1'b1;
         scl_filt_q <= 1'b1;
         sda_filt_q <= 1'b1;
      end else begin
         scl_hist_q <= scl_sync_q[1];
         sda_hist_q <= sda_sync_q[1];
         if ((scl_sync_q[0] == scl_sync_q[1]) && (scl_sync_q[1] == scl_hist_q)) begin
            scl_filt_q <= scl_sync_q[1];
         end
         if ((sda_sync_q[0] == sda_sync_q[1]) && (sda_sync_q[1] == sda_hist_q)) begin
            sda_filt_q <= sda_sync_q[1];
         end
      end
   end

   assign scl_s = scl_filt_q;
   assign sda_s = sda_filt_q;
`else
   assign scl_s = scl_sync_q[1];
   assign sda_s = sda_sync_q[1];
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_prev_q <= scl_s;
         sda_prev_q <= sda_s;
      end
   end

   assign scl_rise  = scl_s & ~scl_prev_q;
   assign scl_fall  = ~scl_s & scl_prev_q;
   assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target: 7-bit address, one-byte register pointer, host-side register port.
// Optional glitch filter in i2c_bus_sync via I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target
   import i2c_pkg::*;
#(
   parameter int unsigned NREGS = 4,
   parameter int unsigned PW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          scl_i,
   input  logic          sda_i,
   output logic          sda_oe,
   input  logic [6:0]    own_addr,
   output logic          wr_valid,
   output logic [PW-1:0] wr_addr,
   output logic [7:0]    wr_data,
   output logic [PW-1:0] rd_addr,
   input  logic [7:0]    rd_data,
   output logic          busy
);

   localparam logic [3:0] LastBit  = 4'(I2C_BYTE_BITS - 1);
   localparam logic [3:0] ByteDone = 4'(I2C_BYTE_BITS);

   logic scl_rise, scl_fall, start_det, stop_det, sda_s;

   i2c_bus_sync u_bus_sync (
      .clk       (clk),
      .reset_n   (reset_n),
      .scl_i     (scl_i),
      .sda_i     (sda_i),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_s     (sda_s)
   );

   i2c_tgt_state_t state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [7:0]     sh_q, sh_d, byte_in;
   logic [PW-1:0]  ptr_q, ptr_d, wa_q, wa_d;
   logic [7:0]     wd_q, wd_d;
   logic           rw_q, rw_d, oe_q, oe_d, busy_q, busy_d, wv_q, wv_d;

   assign byte_in = {sh_q[6:0], sda_s};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         sh_q    <= '0;
         ptr_q   <= '0;
         wa_q    <= '0;
         wd_q    <= '0;
         rw_q    <= 1'b0;
         oe_q    <= 1'b0;
         busy_q  <= 1'b0;
         wv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         ptr_q   <= ptr_d;
         wa_q    <= wa_d;
         wd_q    <= wd_d;
         rw_q    <= rw_d;
         oe_q    <= oe_d;
         busy_q  <= busy_d;
         wv_q    <= wv_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      ptr_d   = ptr_q;
      wa_d    = wa_q;
      wd_d    = wd_q;
      rw_d    = rw_q;
      oe_d    = oe_q;
      busy_d  = busy_q;
      wv_d    = 1'b0;
      if (start_det) begin
         state_d = StAddr;
         cnt_d   = '0;
         oe_d    = 1'b0;
      end else if (stop_det) begin
         state_d = StIdle;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StIgnore: ;
            StAddr, StPtr, StWdata: begin
               if (scl_rise && (cnt_q < ByteDone)) begin
                  sh_d  = byte_in;
                  cnt_d = cnt_q + 4'd1;
                  if (cnt_q == LastBit) begin
                     case (state_q)
                        StAddr: begin
                           if (byte_in[7:1] == own_addr) begin
                              rw_d = byte_in[0];
                           end else begin
                              state_d = StIgnore;
                              busy_d  = 1'b0;
                           end
                        end
                        StPtr: ptr_d = byte_in[PW-1:0];
                        StWdata: begin
                           wv_d  = 1'b1;
                           wa_d  = ptr_q;
                           wd_d  = byte_in;
                           ptr_d = ptr_q + PW'(1);
                        end
                        default: ;
                     endcase
                  end
               end else if (scl_fall && (cnt_q == ByteDone)) begin
                  oe_d = ~I2C_ACK;
                  case (state_q)
                     StAddr: begin
                        state_d = StAddrAck;
                        busy_d  = 1'b1;
                     end
                     StPtr:   state_d = StPtrAck;
                     default: state_d = StWdataAck;
                  endcase
               end
            end
            StAddrAck, StPtrAck, StWdataAck: begin
               if (scl_fall) begin
                  oe_d  = 1'b0;
                  cnt_d = '0;
                  if ((state_q == StAddrAck) && rw_q) begin
                     state_d = StRdata;
                     sh_d    = rd_data;
                     oe_d    = ~rd_data[7];
                  end else if (state_q == StAddrAck) begin
                     state_d = StPtr;
                  end else begin
                     state_d = StWdata;
                  end
               end
            end
            StRdata: begin
               if (scl_rise) begin
                  cnt_d = cnt_q + 4'd1;
                  if (cnt_q == LastBit) begin
                     ptr_d = ptr_q + PW'(1);
                  end
               end else if (scl_fall) begin
                  if (cnt_q == ByteDone) begin
                     state_d = StRdataAck;
                     oe_d    = 1'b0;
                     cnt_d   = '0;
                  end else begin
                     sh_d = {sh_q[6:0], 1'b0};
                     oe_d = ~sh_q[6];
                  end
               end
            end
            StRdataAck: begin
               // cnt_q = 1 marks that the controller ACKed on this clock's rising edge.
               if (scl_rise) begin
                  if (sda_s == I2C_NACK) begin
                     state_d = StIgnore;
                  end else begin
                     cnt_d = 4'd1;
                  end
               end else if (scl_fall && (cnt_q == 4'd1)) begin
                  state_d = StRdata;
                  cnt_d   = '0;
                  sh_d    = rd_data;
                  oe_d    = ~rd_data[7];
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign sda_oe   = oe_q;
   assign wr_valid = wv_q;
   assign wr_addr  = wa_q;
   assign wr_data  = wd_q;
   assign rd_addr  = ptr_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bus-level controller tasks plus a transaction model.
module tb_i2c_target;

   localparam int unsigned NREGS = 4;
   localparam int unsigned PW    = 2;
   localparam int          Q     = 8;
   localparam logic [6:0]  OWN   = 7'h42;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          scl_ctl, sda_ctl, sda_bus;
   logic          sda_oe, wr_valid, busy;
   logic [PW-1:0] wr_addr, rd_addr;
   logic [7:0]    wr_data, rd_data;

   assign sda_bus = sda_ctl & ~sda_oe;
   assign rd_data = 8'hC0 | {6'd0, rd_addr};

   always #5 clk = ~clk;

   i2c_target #(.NREGS(NREGS)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .scl_i    (scl_ctl),
      .sda_i    (sda_bus),
      .sda_oe   (sda_oe),
      .own_addr (OWN),
      .wr_valid (wr_valid),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .busy     (busy)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   int          m_ptr = 0;
   logic [15:0] exp_wr[$];
   bit          quiet_sda = 1'b0;
   bit          quiet_busy = 1'b0;
   logic        wv_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: register read value is 0xC0 | pointer, pointer advances per byte.
   task automatic m_read(output logic [7:0] v);
      v     = 8'hC0 | 8'(m_ptr);
      m_ptr = (m_ptr + 1) % NREGS;
   endtask

   always @(negedge clk) begin
      if (wr_valid) begin
         logic [15:0] e;
         check("wr_single_cycle", {31'd0, wv_prev}, 32'd0);
         if (exp_wr.size() == 0) begin
            check("wr_unexpected", {31'd0, wr_valid}, 32'd0);
         end else begin
            e = exp_wr.pop_front();
            check("wr_addr", {30'd0, wr_addr}, {24'd0, e[15:8]});
            check("wr_data", {24'd0, wr_data}, {24'd0, e[7:0]});
         end
      end
      wv_prev <= wr_valid;
      if (quiet_sda) check("quiet_sda_oe", {31'd0, sda_oe}, 32'd0);
      if (quiet_busy) check("quiet_busy", {31'd0, busy}, 32'd0);
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_c();
      sda_ctl = 1'b0; wait_clk(Q);
      scl_ctl = 1'b0; wait_clk(Q);
   endtask

   task automatic rstart_c();
      sda_ctl = 1'b1; wait_clk(Q);
      scl_ctl = 1'b1; wait_clk(Q);
      sda_ctl = 1'b0; wait_clk(Q);
      scl_ctl = 1'b0; wait_clk(Q);
   endtask

   task automatic stop_c();
      sda_ctl = 1'b0; wait_clk(Q);
      scl_ctl = 1'b1; wait_clk(Q);
      sda_ctl = 1'b1; wait_clk(2 * Q);
   endtask

   task automatic write_bit(input logic b, input int glen);
      sda_ctl = b; wait_clk(Q);
      scl_ctl = 1'b1; wait_clk(Q);
      if (glen > 0) begin
         scl_ctl = 1'b0; wait_clk(glen);
         scl_ctl = 1'b1;
      end
      wait_clk(Q);
      scl_ctl = 1'b0; wait_clk(Q);
   endtask

   task automatic read_bit(output logic b);
      sda_ctl = 1'b1; wait_clk(Q);
      scl_ctl = 1'b1; wait_clk(Q);
      b = sda_bus; wait_clk(Q);
      scl_ctl = 1'b0; wait_clk(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, input int gbit, input int glen,
                             output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(b[i], ((7 - i) == gbit) ? glen : 0);
      read_bit(ack);
   endtask

   task automatic read_byte(output logic [7:0] v);
      logic b;
      v = '0;
      for (int i = 0; i < 8; i++) begin
         read_bit(b);
         v = {v[6:0], b};
      end
   endtask

   task automatic wr_txn(input logic [7:0] a, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input int n, input bit rs, input bit sp,
                         input int gbit, input int glen);
      logic [7:0] d[3];
      logic       ack;
      bit         hit;
      d[0] = d0; d[1] = d1; d[2] = d2;
      hit = (a[7:1] == OWN) && !a[0];
      if (rs) rstart_c(); else start_c();
      write_byte(a, -1, 0, ack);
      check("addr_ack", {31'd0, ack}, hit ? 32'd0 : 32'd1);
      if (hit) check("busy_after_addr", {31'd0, busy}, 32'd1);
      for (int i = 0; i < n; i++) begin
         if (hit) begin
            if (i == 0) begin
               m_ptr = int'(d[i]) % NREGS;
            end else begin
               exp_wr.push_back({8'(m_ptr), d[i]});
               m_ptr = (m_ptr + 1) % NREGS;
            end
         end
         write_byte(d[i], (i == n - 1) ? gbit : -1, glen, ack);
         check("data_ack", {31'd0, ack}, hit ? 32'd0 : 32'd1);
      end
      if (sp) begin
         stop_c();
         check("busy_after_stop", {31'd0, busy}, 32'd0);
      end
   endtask

   initial begin
      logic [7:0] v, e;
      logic       b, ack;
      reset_n = 1'b0;
      scl_ctl = 1'b1;
      sda_ctl = 1'b1;
      wait_clk(3);
      check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
      check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
      check("rst_wr_addr", {30'd0, wr_addr}, 32'd0);
      check("rst_wr_data", {24'd0, wr_data}, 32'd0);
      check("rst_rd_addr", {30'd0, rd_addr}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      reset_n = 1'b1;
      wait_clk(4);

      // Pointer 1, one write of 0xA5.
      wr_txn(8'h84, 8'h01, 8'hA5, 8'h00, 2, 1'b0, 1'b1, -1, 0);
      check("t1_ptr_lit", {30'd0, rd_addr}, 32'd2);
      check("t1_ptr_model", {30'd0, rd_addr}, 32'(m_ptr));

      // Pointer wrap: writes at 3 then 0.
      wr_txn(8'h84, 8'h03, 8'h11, 8'h22, 3, 1'b0, 1'b1, -1, 0);
      check("t2_ptr_lit", {30'd0, rd_addr}, 32'd1);

      // Combined format read.
      wr_txn(8'h84, 8'h02, 8'h00, 8'h00, 1, 1'b0, 1'b0, -1, 0);
      rstart_c();
      write_byte(8'h85, -1, 0, ack);
      check("rd_addr_ack", {31'd0, ack}, 32'd0);
      check("rd_busy", {31'd0, busy}, 32'd1);
      read_byte(v);
      m_read(e);
      check("rd0_model", {24'd0, v}, {24'd0, e});
      check("rd0_lit", {24'd0, v}, 32'hC2);
      write_bit(1'b0, 0);
      read_byte(v);
      m_read(e);
      check("rd1_model", {24'd0, v}, {24'd0, e});
      check("rd1_lit", {24'd0, v}, 32'hC3);
      write_bit(1'b1, 0);
      quiet_sda = 1'b1;
      for (int i = 0; i < 2; i++) begin
         read_bit(b);
         check("rd_after_nack", {31'd0, b}, 32'd1);
      end
      stop_c();
      quiet_sda = 1'b0;
      check("rd_busy_stop", {31'd0, busy}, 32'd0);
      check("rd_ptr_lit", {30'd0, rd_addr}, 32'd0);
      check("rd_ptr_model", {30'd0, rd_addr}, 32'(m_ptr));

      // Address mismatch: bus untouched, never busy.
      quiet_sda  = 1'b1;
      quiet_busy = 1'b1;
      wr_txn(8'h90, 8'h12, 8'h34, 8'h00, 2, 1'b0, 1'b1, -1, 0);
      quiet_sda  = 1'b0;
      quiet_busy = 1'b0;
      check("miss_ptr", {30'd0, rd_addr}, 32'(m_ptr));

      // Reset asserted while driving bit 4 of a read.
      wr_txn(8'h84, 8'h01, 8'h00, 8'h00, 1, 1'b0, 1'b0, -1, 0);
      rstart_c();
      write_byte(8'h85, -1, 0, ack);
      check("rst_rd_ack", {31'd0, ack}, 32'd0);
      m_read(e);
      for (int i = 0; i < 3; i++) begin
         read_bit(b);
         check("rst_rd_bit", {31'd0, b}, {31'd0, e[7 - i]});
      end
      scl_ctl = 1'b1;
      wait_clk(Q);
      check("rst_pre_drive", {31'd0, sda_oe}, 32'd1);
      #2 reset_n = 1'b0;
      #1 check("rst_async_oe", {31'd0, sda_oe}, 32'd0);
      check("rst_async_busy", {31'd0, busy}, 32'd0);
      check("rst_async_ptr", {30'd0, rd_addr}, 32'd0);
      m_ptr = 0;
      wait_clk(4);
      scl_ctl = 1'b1;
      sda_ctl = 1'b1;
      reset_n = 1'b1;
      wait_clk(4);
      wr_txn(8'h84, 8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b1, -1, 0);
      check("post_rst_ptr", {30'd0, rd_addr}, 32'd0);
      wr_txn(8'h84, 8'h03, 8'h77, 8'h00, 2, 1'b0, 1'b1, -1, 0);
      check("post_rst_ptr2", {30'd0, rd_addr}, 32'd0);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
      // 2-clk SCL glitch is swallowed: the byte arrives intact.
      wr_txn(8'h84, 8'h01, 8'hA5, 8'h00, 2, 1'b0, 1'b1, 2, 2);
      // 3-clk glitch duplicates the first bit: 1,1,0,1,0,0,1,0 = 0xD2 at pointer 0.
      start_c();
      write_byte(8'h84, -1, 0, ack);
      check("gl_addr_ack", {31'd0, ack}, 32'd0);
      m_ptr = 0;
      write_byte(8'h00, -1, 0, ack);
      check("gl_ptr_ack", {31'd0, ack}, 32'd0);
      exp_wr.push_back({8'h00, 8'hD2});
      m_ptr = 1;
      write_byte(8'hA5, 0, 3, ack);
      stop_c();
      check("gl_ptr", {30'd0, rd_addr}, 32'd1);
`endif

      wait_clk(10);
      check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
